lf_adder_arbiter: RTL

//  Shares one 64-bit Ladner-Fischer prefix adder (the existing group-G/P network) between two requesters.

---
 rtl/lf_adder_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/lf_adder_arbiter.sv
// Two-requester front end for a shared 64-bit Ladner-Fischer adder.
// Round-robin grant, operand register, combinational prefix adder, per-requester 1-entry response buffers.
module lf_adder_arbiter #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  logic [2*WIDTH-1:0] req_a_i,
    input  logic [2*WIDTH-1:0] req_b_i,
    input  logic [1:0]         req_cin_i,
    input  logic [1:0]         req_sub_i,
    output logic [1:0]         rsp_valid_o,
    input  logic [1:0]         rsp_ready_i,
    output logic [2*WIDTH-1:0] rsp_sum_o,
    output logic [1:0]         rsp_cout_o,
    output logic [1:0]         rsp_ovf_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   op_cnt_o
);

    localparam int LEVELS = $clog2(WIDTH);

    if (WIDTH != 64) begin : g_bad_width
        $error("lf_adder_arbiter: prefix network is fixed at 64 bits");
    end

    logic             rr_last;
    logic             s1_vld;
    logic             s1_owner;
    logic             s1_sub;
    logic             s1_cin;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic [1:0]       eligible;
    logic [1:0]       cand;
    logic [1:0]       grant;
    logic             grant_idx;

    // A requester is blocked while its op is in the operand stage or its result is unread.
    always_comb begin
        eligible[0] = !rsp_valid_o[0] && !(s1_vld && !s1_owner);
        eligible[1] = !rsp_valid_o[1] && !(s1_vld &&  s1_owner);
    end

    assign cand = req_valid_i & eligible;

    always_comb begin
        grant = 2'b00;
        case (cand)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign grant_idx   = grant[1];
    assign req_ready_o = grant;
    assign busy_o      = s1_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last  <= 1'b1;
            s1_vld   <= 1'b0;
            s1_owner <= 1'b0;
            s1_sub   <= 1'b0;
            s1_cin   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_vld <= |grant;
            if (|grant) begin
                rr_last  <= grant_idx;
                s1_owner <= grant_idx;
                s1_sub   <= grant_idx ? req_sub_i[1] : req_sub_i[0];
                s1_cin   <= grant_idx ? req_cin_i[1] : req_cin_i[0];
                s1_a     <= grant_idx ? req_a_i[2*WIDTH-1:WIDTH] : req_a_i[WIDTH-1:0];
                s1_b     <= grant_idx ? req_b_i[2*WIDTH-1:WIDTH] : req_b_i[WIDTH-1:0];
            end
        end
    end

    logic [WIDTH-1:0] b_eff;
    logic             c_in;
    logic [WIDTH-1:0] g_lvl [LEVELS+1];
    logic [WIDTH-1:0] p_lvl [LEVELS+1];
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    assign b_eff = s1_sub ? ~s1_b : s1_b;
    assign c_in  = s1_sub | s1_cin;

    // Ladner-Fischer: at level l, every bit with bit l of its index set merges
    // with the top bit of the preceding 2^l block; after LEVELS levels each
    // bit holds the group G/P over [i:0].
    always_comb begin
        int j;
        g_lvl[0] = s1_a & b_eff;
        p_lvl[0] = s1_a ^ b_eff;
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                j = ((i >> l) << l) - 1;
                if (((i >> l) & 1) != 0) begin
                    g_lvl[l+1][i] = g_lvl[l][i] | (p_lvl[l][i] & g_lvl[l][j]);
                    p_lvl[l+1][i] = p_lvl[l][i] & p_lvl[l][j];
                end else begin
                    g_lvl[l+1][i] = g_lvl[l][i];
                    p_lvl[l+1][i] = p_lvl[l][i];
                end
            end
        end
    end

    assign carry = g_lvl[LEVELS] | (p_lvl[LEVELS] & {WIDTH{c_in}});
    assign sum   = p_lvl[0] ^ {carry[WIDTH-2:0], c_in};
    assign cout  = carry[WIDTH-1];
    assign ovf   = carry[WIDTH-1] ^ carry[WIDTH-2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_o <= '0;
            rsp_sum_o   <= '0;
            rsp_cout_o  <= '0;
            rsp_ovf_o   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s1_vld && (s1_owner == 1'(i))) begin
                    rsp_valid_o[i]               <= 1'b1;
                    rsp_sum_o[i*WIDTH +: WIDTH]  <= sum;
                    rsp_cout_o[i]                <= cout;
                    rsp_ovf_o[i]                 <= ovf;
                end else if (rsp_valid_o[i] && rsp_ready_i[i]) begin
                    rsp_valid_o[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_o <= '0;
        end else if (s1_vld && !(&op_cnt_o)) begin
            op_cnt_o <= op_cnt_o + 1'b1;
        end
    end

endmodule
